// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read RAM slave and its address generator.
// Holds burst/response encodings, the slave state enum and a helper that
// tells whether a burst length is usable for WRAP.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_read_ram_burst_if.sv
// AXI4 read channel bundle (AR + R) between an interconnect master and the
// read RAM slave.
//   araddr/arlen/arsize/arburst/arvalid : master -> slave request
//   arready                             : slave -> master request accept
//   rdata/rresp/rlast/rvalid            : slave -> master beat
//   rready                              : master -> slave beat accept
interface axi_read_ram_burst_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic                     rvalid;
  logic                     rready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address calculator (FIXED / INCR / WRAP).
//   addr_i      : address of the current beat
//   size_i      : log2 bytes per beat
//   len_i       : beats minus one (sets the WRAP window)
//   burst_i     : burst type encoding
//   next_addr_o : address of the following beat, modulo 2^ADDRESS_WIDTH
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [2:0]               size_i,
  input  logic [7:0]               len_i,
  input  logic [1:0]               burst_i,
  output logic [ADDRESS_WIDTH-1:0] next_addr_o
);

  logic [ADDRESS_WIDTH-1:0] step;
  logic [ADDRESS_WIDTH-1:0] wrap_mask;
  logic [ADDRESS_WIDTH-1:0] boundary;

  always_comb begin
    step = ADDRESS_WIDTH'(1) << size_i;
    // A window at least as large as the address space truncates to zero,
    // so the mask becomes all ones, which is the correct modulus.
    wrap_mask = (step * ADDRESS_WIDTH'({1'b0, len_i} + 9'd1)) - ADDRESS_WIDTH'(1);
    boundary  = addr_i & ~wrap_mask;
    next_addr_o = addr_i;
    case (burst_i)
      AXI_BURST_INCR: next_addr_o = (addr_i & ~(step - ADDRESS_WIDTH'(1))) + step;
      AXI_BURST_WRAP: next_addr_o = boundary + ((addr_i + step - boundary) & wrap_mask);
      default:        next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_ram_burst.sv
// AXI4 read-only slave RAM with a backdoor preload port.
// One burst outstanding; beats are fetched from storage into registered
// outputs, so the first beat follows the AR handshake by one cycle and
// consecutive beats stream with no bubbles while rready is high.
//   aclk, aresetn          : clock, async active-low reset
//   axi                    : AR/R channel (slave modport)
//   wr_en/wr_addr/wr_data  : backdoor word write, any state
//
// state    | meaning
// ST_IDLE  | waiting for a request (arready high once out of reset)
// ST_BURST | presenting beats, rvalid high until the last handshake
module axi_read_ram_burst
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axi_read_ram_burst_if.slave      axi,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LG    = $clog2(BYTES);
  localparam int MAW   = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                   state_q, state_d;
  logic                     arready_q, arready_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  logic [2:0]               size_q, size_d;
  logic [1:0]               burst_q, burst_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     rlast_q, rlast_d;

  logic [ADDRESS_WIDTH-1:0] next_addr;
  logic [ADDRESS_WIDTH-1:0] beat_addr;
  logic [ADDRESS_WIDTH-1:0] word_idx;
  logic                     beat_err;
  logic                     beat_oob;
  logic                     load_beat;
  logic                     ar_err;
  logic                     wr_ok;

  axi_burst_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_addr_gen (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .len_i      (len_q),
    .burst_i    (burst_q),
    .next_addr_o(next_addr)
  );

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    beat_addr = addr_q;
    beat_err  = err_q;
    load_beat = 1'b0;

    ar_err = (axi.arburst == AXI_BURST_RSVD) ||
             (int'(axi.arsize) > LG) ||
             ((axi.arburst == AXI_BURST_WRAP) && !wrap_len_ok(axi.arlen));

    unique case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          state_d   = ST_BURST;
          arready_d = 1'b0;
          addr_d    = axi.araddr;
          len_d     = axi.arlen;
          size_d    = axi.arsize;
          burst_d   = axi.arburst;
          cnt_d     = 8'd0;
          err_d     = ar_err;
          rlast_d   = (axi.arlen == 8'd0);
          beat_addr = axi.araddr;
          beat_err  = ar_err;
          load_beat = 1'b1;
        end
      end
      ST_BURST: begin
        if (axi.rready) begin
          if (cnt_q == len_q) begin
            state_d   = ST_IDLE;
            arready_d = 1'b1;
            rlast_d   = 1'b0;
            rresp_d   = AXI_RESP_OKAY;
            rdata_d   = '0;
          end else begin
            cnt_d     = cnt_q + 8'd1;
            addr_d    = next_addr;
            rlast_d   = ((cnt_q + 8'd1) == len_q);
            beat_addr = next_addr;
            load_beat = 1'b1;
          end
        end
      end
      default: ;
    endcase

    word_idx = beat_addr >> LG;
    beat_oob = ({1'b0, word_idx} >= (ADDRESS_WIDTH + 1)'(DEPTH));
    if (load_beat) begin
      if (beat_err || beat_oob) begin
        rresp_d = AXI_RESP_SLVERR;
        rdata_d = '0;
      end else begin
        rresp_d = AXI_RESP_OKAY;
        // Read happens before this edge's backdoor write lands: old data wins.
        rdata_d = mem[word_idx[MAW-1:0]];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= AXI_BURST_FIXED;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign wr_ok = ({1'b0, wr_addr} < (MAW + 1)'(DEPTH));

  always_ff @(posedge aclk) begin
    if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = (state_q == ST_BURST);
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_read_ram_burst.sv
module tb_axi_read_ram_burst;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        aclk;
  logic        aresetn;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  axi_read_ram_burst_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

  axi_read_ram_burst #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .axi    (rif.slave),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  logic [31:0] mem_model [DEPTH];
  beat_t       exp_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          beats_done = 0;
  bit          mon_en   = 0;
  bit          stall_en = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Reference: beat i's address is derived in closed form from the start
  // address, then the word is looked up in the model memory.
  function automatic void push_burst(input int a, input int len, input int sz, input int bt);
    bit berr;
    int step, wb, aligned, bnd, ba, widx;
    beat_t b;
    berr = (bt == 3) || (sz > 2) ||
           ((bt == 2) && !(len == 1 || len == 3 || len == 7 || len == 15));
    step    = 1 << sz;
    wb      = step * (len + 1);
    aligned = a & ~(step - 1);
    bnd     = a & ~(wb - 1);
    for (int i = 0; i <= len; i++) begin
      case (bt)
        1:       ba = (i == 0) ? a : (aligned + i * step) % 256;
        2:       ba = (bnd + ((a - bnd + i * step) % wb)) % 256;
        default: ba = a;
      endcase
      widx = ba >> 2;
      if (berr || widx >= DEPTH) begin
        b.data = 32'h0;
        b.resp = 2'b10;
      end else begin
        b.data = mem_model[widx];
        b.resp = 2'b00;
      end
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endfunction

  // Scoreboard monitor: while a beat is presented it must match the head of
  // the queue (which also covers stability while stalled); it pops on handshake.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (rif.rvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(rif.rvalid), 64'(0));
        end else begin
          check("beat", {29'b0, rif.rdata, rif.rresp, rif.rlast},
                {29'b0, exp_q[0].data, exp_q[0].resp, exp_q[0].last});
          if (rif.rready) begin
            void'(exp_q.pop_front());
            beats_done++;
          end
        end
        check("arready_busy", 64'(rif.arready), 64'(0));
      end else begin
        check("rvalid_held", 64'(exp_q.size() != 0), 64'(0));
        check("arready_idle", 64'(rif.arready), 64'(1));
      end
    end
  end

  initial begin
    rif.rready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      rif.rready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_ar(input int a, input int len, input int sz, input int bt);
    int n = 0;
    @(negedge aclk);
    while (!rif.arready && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    if (!rif.arready) begin
      fail_now("ar_accept_timeout");
      return;
    end
    rif.araddr  = 8'(a);
    rif.arlen   = 8'(len);
    rif.arsize  = 3'(sz);
    rif.arburst = 2'(bt);
    rif.arvalid = 1'b1;
    @(posedge aclk);
    #1;
    rif.arvalid = 1'b0;
    push_burst(a, len, sz, bt);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((exp_q.size() != 0 || rif.rvalid) && n < 5000);
    if (n >= 5000) fail_now("idle_timeout");
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    @(negedge aclk);
    wr_en   = 1'b1;
    wr_addr = 5'(idx);
    wr_data = d;
    mem_model[idx] = d;
    @(negedge aclk);
    wr_en = 1'b0;
  endtask

  initial begin
    int b0, n, bt, sz, len, a;
    aresetn     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rif.arvalid = 1'b0;
    rif.araddr  = '0;
    rif.arlen   = '0;
    rif.arsize  = '0;
    rif.arburst = '0;

    #22;
    check("rst_arready", 64'(rif.arready), 64'(0));
    check("rst_rvalid",  64'(rif.rvalid),  64'(0));
    check("rst_rlast",   64'(rif.rlast),   64'(0));
    check("rst_rresp",   64'(rif.rresp),   64'(0));
    check("rst_rdata",   64'(rif.rdata),   64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("arready_before_edge", 64'(rif.arready), 64'(0));
    @(posedge aclk);
    #1;
    check("arready_after_edge", 64'(rif.arready), 64'(1));
    mon_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) bd_write(i, 32'(i) * 32'h11111111);

    send_ar(8'h08, 3, 2, 1);  wait_idle();
    send_ar(8'h34, 3, 2, 2);  wait_idle();
    send_ar(8'hF8, 3, 2, 1);  wait_idle();
    send_ar(8'h00, 1, 2, 3);  wait_idle();
    send_ar(8'h00, 1, 3, 1);  wait_idle();
    send_ar(8'h10, 2, 2, 2);  wait_idle();

    stall_en = 1'b1;
    send_ar(8'h10, 15, 2, 0); wait_idle();
    stall_en = 1'b0;

    send_ar(8'h20, 2, 2, 1);
    send_ar(8'h40, 1, 2, 1);
    wait_idle();

    // Abandon an 8-beat burst part way through with a reset pulse.
    send_ar(8'h00, 7, 2, 1);
    b0 = beats_done;
    n  = 0;
    while (beats_done < b0 + 2 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    if (beats_done < b0 + 2) fail_now("reset_setup_timeout");
    mon_en  = 1'b0;
    aresetn = 1'b0;
    #1;
    check("midrst_rvalid",  64'(rif.rvalid),  64'(0));
    check("midrst_arready", 64'(rif.arready), 64'(0));
    check("midrst_rlast",   64'(rif.rlast),   64'(0));
    check("midrst_rdata",   64'(rif.rdata),   64'(0));
    exp_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_arready_before_edge", 64'(rif.arready), 64'(0));
    @(posedge aclk);
    #1;
    check("rel_arready_after_edge", 64'(rif.arready), 64'(1));
    mon_en = 1'b1;
    send_ar(8'h0C, 3, 2, 1);  wait_idle();

    for (int t = 0; t < 40; t++) begin
      stall_en = ($urandom_range(0, 1) == 1);
      n  = $urandom_range(0, 9);
      bt = (n < 3) ? 0 : (n < 7) ? 1 : (n < 9) ? 2 : 3;
      sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (bt == 2 && $urandom_range(0, 9) != 0) begin
        case ($urandom_range(0, 3))
          0:       len = 1;
          1:       len = 3;
          2:       len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 20);
      end
      a = $urandom_range(0, 255);
      send_ar(a, len, sz, bt);
      wait_idle();
      if ($urandom_range(0, 3) == 0) bd_write($urandom_range(0, DEPTH - 1), $urandom);
    end
    stall_en = 1'b0;
    send_ar(8'h04, 255, 2, 1); wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
